// File: rtl/req_issuer.sv
// req_issuer: ID-tagged add/mul command issuer with tag table, backpressure and drain; optional per-ID timeout via REQ_ISSUER_TIMEOUT_EN
package req_issuer_pkg;
    typedef struct packed {
        logic        req;
        logic [2:0]  req_id;
        logic        req_type;
        logic [31:0] req_data1;
        logic [31:0] req_data2;
    } req_pkt_type;
    typedef struct packed {
        logic        rsp;
        logic [2:0]  rsp_id;
        logic [63:0] rsp_data;
    } rsp_pkt_type;
endpackage

module req_issuer
    import req_issuer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
`ifdef REQ_ISSUER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_type,
    input  logic [31:0] cmd_data1,
    input  logic [31:0] cmd_data2,
    output req_pkt_type req_out,
    input  logic        fifo_full,
    input  rsp_pkt_type rsp_in,
    output logic        res_valid,
    output logic [2:0]  res_id,
    output logic        res_type,
    output logic [63:0] res_data,
    input  logic        drain_req,
    output logic        idle,
    output logic [3:0]  outstanding,
`ifdef REQ_ISSUER_TIMEOUT_EN
    output logic        err_timeout,
`endif
    output logic        err_unexp
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DRAINED} state_t;

    state_t     state, state_n;
    logic [7:0] busy, typ, expire;
    logic [2:0] alloc_ptr, alloc_id, scan_id;
    logic       found, accept, rsp_hit, rsp_miss;

    // Lowest free ID at or above the alloc pointer, wrapping; descending scan so the nearest wins
    always_comb begin
        found    = 1'b0;
        alloc_id = '0;
        scan_id  = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            scan_id = 3'((int'(alloc_ptr) + i) % MAX_OUTSTANDING);
            if (!busy[scan_id]) begin
                found    = 1'b1;
                alloc_id = scan_id;
            end
        end
    end

    assign cmd_ready   = !rst && (state == IDLE || state == ACTIVE) && !drain_req && found && !fifo_full;
    assign accept      = cmd_valid && cmd_ready;
    assign rsp_hit     = rsp_in.rsp && busy[rsp_in.rsp_id];
    assign rsp_miss    = rsp_in.rsp && !busy[rsp_in.rsp_id];
    assign outstanding = 4'($countones(busy));
    assign idle        = (busy == '0) && (state == IDLE || state == DRAINED);

    // Next-state logic: drain stops intake, DRAINED holds until drain_req drops
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = ACTIVE;
            ACTIVE:  if (drain_req) state_n = DRAIN;
                     else if (outstanding == 4'd0 && !accept) state_n = IDLE;
            DRAIN:   if (outstanding == 4'd0) state_n = DRAINED;
            DRAINED: if (!drain_req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef REQ_ISSUER_TIMEOUT_EN
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
    logic [AW-1:0] age [8];

    // An ID expires on the edge its age would reach the deadline, unless its response lands that edge
    always_comb begin
        expire = '0;
        for (int i = 0; i < 8; i++)
            expire[i] = busy[i] && age[i] == AW'(TIMEOUT_CYCLES - 1) && !(rsp_hit && rsp_in.rsp_id == 3'(i));
    end

    // Age counters restart on allocation and run while the ID is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) age[i] <= '0;
            err_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++)
                age[i] <= (accept && alloc_id == 3'(i)) ? '0 : busy[i] ? age[i] + 1'b1 : age[i];
            err_timeout <= err_timeout | (|expire);
        end
    end
`else
    assign expire = '0;
`endif

    // Tag table, alloc pointer, registered request/result outputs and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= '0;
            typ       <= '0;
            alloc_ptr <= '0;
            req_out   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_type  <= 1'b0;
            res_data  <= '0;
            err_unexp <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= (busy & ~expire & ~(rsp_hit ? 8'd1 << rsp_in.rsp_id : 8'd0)) | (accept ? 8'd1 << alloc_id : 8'd0);
            if (accept) begin
                typ[alloc_id] <= cmd_type;
                alloc_ptr     <= alloc_id == 3'(MAX_OUTSTANDING - 1) ? 3'd0 : alloc_id + 3'd1;
            end
            req_out   <= accept ? {1'b1, alloc_id, cmd_type, cmd_data1, cmd_data2} : '0;
            res_valid <= rsp_hit;
            if (rsp_hit) begin
                res_id   <= rsp_in.rsp_id;
                res_type <= typ[rsp_in.rsp_id];
                res_data <= rsp_in.rsp_data;
            end
            err_unexp <= err_unexp | rsp_miss;
        end
    end

endmodule

// File: tb/tb_req_issuer.sv
// tb_req_issuer: directed plus randomized checks of req_issuer against a tag-table reference model
module tb_req_issuer;
    import req_issuer_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_type = 1'b0, fifo_full = 1'b0, drain_req = 1'b0;
    logic [31:0] cmd_data1 = '0, cmd_data2 = '0;
    rsp_pkt_type rsp_in = '0;
    req_pkt_type req_out;
    logic        cmd_ready, res_valid, res_type, idle, err_unexp;
    logic [2:0]  res_id;
    logic [63:0] res_data;
    logic [3:0]  outstanding;

    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    req_issuer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_data1(cmd_data1), .cmd_data2(cmd_data2), .req_out(req_out), .fifo_full(fifo_full),
        .rsp_in(rsp_in), .res_valid(res_valid), .res_id(res_id), .res_type(res_type),
        .res_data(res_data), .drain_req(drain_req), .idle(idle), .outstanding(outstanding),
        .err_unexp(err_unexp)
    );

    // Reference model: 0=IDLE 1=ACTIVE 2=DRAIN 3=DRAINED
    bit          m_busy [8];
    bit          m_typ [8];
    int          m_ptr, m_st;
    bit          m_err, m_rv, m_rt;
    req_pkt_type m_req;
    logic [2:0]  m_rid;
    logic [63:0] m_rd;

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_rdy();
        return !rst && m_st <= 1 && !drain_req && m_cnt() < 8 && !fifo_full;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 0;
            m_typ[i]  = 0;
        end
        m_ptr = 0; m_st = 0; m_err = 0; m_rv = 0; m_rt = 0;
        m_req = '0; m_rid = '0; m_rd = '0;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("cmd_ready", 72'(cmd_ready), 72'(m_rdy()));
        check("req_out", 72'(req_out), 72'(m_req));
        check("res_valid", 72'(res_valid), 72'(m_rv));
        check("res_id", 72'(res_id), 72'(m_rid));
        check("res_type", 72'(res_type), 72'(m_rt));
        check("res_data", 72'(res_data), 72'(m_rd));
        check("idle", 72'(idle), 72'(m_cnt() == 0 && (m_st == 0 || m_st == 3)));
        check("outstanding", 72'(outstanding), 72'(m_cnt()));
        check("err_unexp", 72'(err_unexp), 72'(m_err));
    endtask

    // Called just after a falling edge with inputs set; checks, advances the model, waits one cycle
    task automatic tick();
        int id;
        bit acc, hit;
        int cnt;
        #1 check_all();
        id  = -1;
        cnt = m_cnt();
        acc = cmd_valid && m_rdy();
        hit = rsp_in.rsp && m_busy[rsp_in.rsp_id];
        if (acc)
            for (int k = 0; k < 8; k++)
                if (id < 0 && !m_busy[(m_ptr + k) % 8]) id = (m_ptr + k) % 8;
        if (rsp_in.rsp && !hit) m_err = 1;
        case (m_st)
            0: if (acc) m_st = 1;
            1: if (drain_req) m_st = 2; else if (cnt == 0 && !acc) m_st = 0;
            2: if (cnt == 0) m_st = 3;
            default: if (!drain_req) m_st = 0;
        endcase
        m_req = acc ? {1'b1, 3'(id), cmd_type, cmd_data1, cmd_data2} : '0;
        m_rv  = hit;
        if (hit) begin
            m_rid = rsp_in.rsp_id;
            m_rt  = m_typ[rsp_in.rsp_id];
            m_rd  = rsp_in.rsp_data;
            m_busy[rsp_in.rsp_id] = 0;
        end
        if (acc) begin
            m_busy[id] = 1;
            m_typ[id]  = cmd_type;
            m_ptr      = (id + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic cmd(input bit v, input bit t, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = v; cmd_type = t; cmd_data1 = a; cmd_data2 = b;
    endtask

    task automatic rsp(input bit v, input logic [2:0] id, input logic [63:0] d);
        rsp_in = {v, id, d};
    endtask

    task automatic reset_pulse();
        cmd(0, 0, 0, 0);
        rsp(0, 0, 0);
        fifo_full = 0;
        drain_req = 0;
        rst = 1;
        #1 m_reset();
        check_all();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        m_reset();
        #1 check_all();
        @(negedge clk);
        rst = 0;

        // Single add: 5 + 7 returned as 12
        cmd(1, 0, 5, 7);
        tick();
        check("t1_req", 72'(req_out.req), 72'(1));
        check("t1_req_id", 72'(req_out.req_id), 72'(0));
        cmd(0, 0, 0, 0);
        rsp(1, 0, 64'd12);
        tick();
        rsp(0, 0, 0);
        check("t1_res_valid", 72'(res_valid), 72'(1));
        check("t1_res_data", 72'(res_data), 72'(12));
        tick();
        tick();
        check("t1_idle", 72'(idle), 72'(1));

        // Fill all eight tags back to back, then free ID 3 and reallocate it
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            cmd(1, 1'($urandom), $urandom, $urandom);
            tick();
            check("t2_req_id", 72'(req_out.req_id), 72'(i));
        end
        #1 check("t2_full_cnt", 72'(outstanding), 72'(8));
        check("t2_full_rdy", 72'(cmd_ready), 72'(0));
        tick();
        cmd(0, 0, 0, 0);
        rsp(1, 3, 64'h33);
        tick();
        rsp(0, 0, 0);
        cmd(1, 1, 32'hA, 32'hB);
        tick();
        check("t2_realloc_id", 72'(req_out.req_id), 72'(3));

        // Backpressure: fifo_full blocks three cycles, then the command goes through
        cmd(0, 0, 0, 0);
        rsp(1, 0, 64'h1);
        tick();
        rsp(1, 1, 64'h2);
        tick();
        rsp(0, 0, 0);
        cmd(1, 0, 32'h11, 32'h22);
        fifo_full = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_bp_rdy", 72'(cmd_ready), 72'(0));
            check("t3_bp_req", 72'(req_out.req), 72'(0));
        end
        fifo_full = 0;
        tick();
        check("t3_release_req", 72'(req_out.req), 72'(1));
        cmd(0, 0, 0, 0);

        // Retire everything, then an unexpected response for free ID 5
        for (int i = 0; i < 8; i++)
            if (m_busy[i]) begin
                rsp(1, 3'(i), {$urandom, $urandom});
                tick();
            end
        rsp(1, 5, 64'h55);
        tick();
        rsp(0, 0, 0);
        check("t4_no_res", 72'(res_valid), 72'(0));
        check("t4_err", 72'(err_unexp), 72'(1));
        tick();
        tick();
        check("t4_err_sticky", 72'(err_unexp), 72'(1));
        check("t4_cnt", 72'(outstanding), 72'(0));

        // Drain with four outstanding
        for (int i = 0; i < 4; i++) begin
            cmd(1, 1'(i), $urandom, $urandom);
            tick();
        end
        drain_req = 1;
        cmd(1, 0, 1, 1);
        tick();
        check("t5_drain_rdy", 72'(cmd_ready), 72'(0));
        cmd(0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            if (m_busy[i]) begin
                rsp(1, 3'(i), {$urandom, $urandom});
                tick();
            end
        rsp(0, 0, 0);
        for (int i = 0; i < 10 && !idle; i++) tick();
        check("t5_drained_idle", 72'(idle), 72'(1));
        drain_req = 0;
        tick();
        tick();
        check("t5_ready_again", 72'(cmd_ready), 72'(1));

        // Reset with three outstanding; a late response flags err_unexp
        for (int i = 0; i < 3; i++) begin
            cmd(1, 0, $urandom, $urandom);
            tick();
        end
        reset_pulse();
        check("t6_rst_req", 72'(req_out), 72'(0));
        check("t6_rst_cnt", 72'(outstanding), 72'(0));
        rsp(1, 1, 64'hDEAD);
        tick();
        rsp(0, 0, 0);
        tick();
        check("t6_late_err", 72'(err_unexp), 72'(1));

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            cmd(1'($urandom % 2), 1'($urandom), $urandom, $urandom);
            fifo_full = ($urandom % 5) == 0;
            if ($urandom % 40 == 0) drain_req = !drain_req;
            rsp(($urandom % 3) == 0, 3'($urandom), {$urandom, $urandom});
            tick();
        end
        cmd(0, 0, 0, 0);
        rsp(0, 0, 0);
        fifo_full = 0;
        drain_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
